// File: rtl/sobel_pkg.sv
// sobel_pkg
// Shared definitions for the Sobel shift-window controller:
//   - pixel / word geometry of the shifter (16-bit pixels, 64-bit words)
//   - width of the beat/pause down-counter
//   - sequencer state encoding
//   - helper that converts a cycle count into a down-counter preset
package sobel_pkg;

  localparam int unsigned PIX_BITS     = 16;
  localparam int unsigned WORD_BITS    = 64;
  localparam int unsigned PIX_PER_WORD = WORD_BITS / PIX_BITS;

  // Wide enough for any practical BEATS/PAUSE setting.
  localparam int unsigned TIMER_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_SHIFT,
    ST_PAUSE,
    ST_DONE
  } state_t;

  // The timer flags terminal count when it reaches zero, so a phase of
  // n cycles is preset to n-1. A zero-length phase is never loaded.
  function automatic logic [TIMER_W-1:0] timer_preset(input int unsigned n);
    return (n == 0) ? '0 : TIMER_W'(n - 1);
  endfunction

endpackage

// File: rtl/sobel_beat_timer.sv
// sobel_beat_timer
// Loadable down-counter used by the sequencer to time the shift beats of a
// word and the idle pause that follows them.
// Ports:
//   clk     in   system clock
//   reset   in   asynchronous, active-high; clears the count
//   load    in   load 'value' into the counter (has priority over counting)
//   value   in   preset value (phase length minus one)
//   freeze  in   hold the count this cycle
//   tc      out  terminal count: counter is at zero
module sobel_beat_timer
  import sobel_pkg::*;
#(
  parameter int unsigned W = TIMER_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         freeze,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (!freeze && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/sobel_shift_sequencer.sv
// sobel_shift_sequencer
// Handshaked, stall-aware scheduler for the Sobel shift-window datapath.
// For each 64-bit word set it requests the word from the line buffers,
// issues one load strobe and BEATS shift strobes (each one presenting a
// window), optionally idles PAUSE cycles, then advances the pixel address
// by one word until the word containing ENDADDRESS has been processed.
// Parameters:
//   STARTADDRESS  first pixel address of the frame range
//   ENDADDRESS    last pixel address of the frame range (inclusive)
//   BEATS         shift strobes per loaded word (must be >= 1)
//   PAUSE         idle cycles after the last shift of a word (0 allowed)
//   PIXW          pixel counter / address width
//   PIXPERWORD    pixels per 64-bit word
// Ports:
//   clk           in   system clock (shifter consumes strobes on falling edge)
//   reset         in   asynchronous, active-high
//   start         in   one-cycle pulse, begins a frame when idle
//   rdValid       in   line-buffer words for rdAddr are valid
//   stall         in   downstream cannot accept a window (registered source)
//   rdReq         out  request word set at rdAddr
//   rdAddr        out  pixel address of the requested word
//   loadEn        out  load low 64 bits of each shift buffer
//   shiftEn       out  shift each buffer one pixel toward MSB
//   outValid      out  window at the shifter top is valid this cycle
//   pixelCounter  out  address of the word currently in the window
//   busy          out  frame in progress
//   done          out  one-cycle pulse at frame end
module sobel_shift_sequencer
  import sobel_pkg::*;
#(
  parameter int unsigned STARTADDRESS = 0,
  parameter int unsigned ENDADDRESS   = 4194303,
  parameter int unsigned BEATS        = 3,
  parameter int unsigned PAUSE        = 1,
  parameter int unsigned PIXW         = 24,
  parameter int unsigned PIXPERWORD   = PIX_PER_WORD
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            rdValid,
  input  logic            stall,
  output logic            rdReq,
  output logic [PIXW-1:0] rdAddr,
  output logic            loadEn,
  output logic            shiftEn,
  output logic            outValid,
  output logic [PIXW-1:0] pixelCounter,
  output logic            busy,
  output logic            done
);

  state_t               state;
  state_t               state_next;
  logic [PIXW-1:0]      pc_next;

  logic                 timer_load;
  logic [TIMER_W-1:0]   timer_value;
  logic                 timer_freeze;
  logic                 timer_tc;

  logic [PIXW:0]        next_word;
  logic                 last_word;
  logic                 word_end;

  // End-of-range test is done one bit wider than the counter so a range
  // ending at the top of the address space cannot wrap back to zero.
  // An unaligned ENDADDRESS makes the word containing it the last one.
  assign next_word = {1'b0, pixelCounter} + (PIXW+1)'(PIXPERWORD);
  assign last_word = (next_word > (PIXW+1)'(ENDADDRESS));

  // The timer only runs while shifting (and not stalled) or pausing.
  assign timer_freeze = !(((state == ST_SHIFT) && !stall) || (state == ST_PAUSE));

  sobel_beat_timer #(
    .W (TIMER_W)
  ) u_beat_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (timer_load),
    .value  (timer_value),
    .freeze (timer_freeze),
    .tc     (timer_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      pixelCounter <= PIXW'(STARTADDRESS);
    end else begin
      state        <= state_next;
      pixelCounter <= pc_next;
    end
  end

  always_comb begin
    state_next  = state;
    pc_next     = pixelCounter;
    timer_load  = 1'b0;
    timer_value = '0;
    word_end    = 1'b0;
    rdReq       = 1'b0;
    loadEn      = 1'b0;
    shiftEn     = 1'b0;
    outValid    = 1'b0;
    done        = 1'b0;
    busy        = (state != ST_IDLE);

    unique case (state)
      ST_IDLE: begin
        if (start) begin
          pc_next    = PIXW'(STARTADDRESS);
          state_next = ST_FETCH;
        end
      end

      ST_FETCH: begin
        rdReq = 1'b1;
        if (rdValid) begin
          state_next = ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (!stall) begin
          loadEn      = 1'b1;
          outValid    = 1'b1;
          timer_load  = 1'b1;
          timer_value = timer_preset(BEATS);
          state_next  = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (!stall) begin
          shiftEn  = 1'b1;
          outValid = 1'b1;
          // Terminal count here means this strobe is the word's last shift.
          if (timer_tc) begin
            if (PAUSE != 0) begin
              timer_load  = 1'b1;
              timer_value = timer_preset(PAUSE);
              state_next  = ST_PAUSE;
            end else begin
              word_end = 1'b1;
            end
          end
        end
      end

      ST_PAUSE: begin
        if (timer_tc) begin
          word_end = 1'b1;
        end
      end

      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Shared end-of-word step, reached from the last shift or the last pause cycle.
    if (word_end) begin
      if (last_word) begin
        state_next = ST_DONE;
      end else begin
        pc_next    = pixelCounter + PIXW'(PIXPERWORD);
        state_next = ST_FETCH;
      end
    end
  end

  assign rdAddr = pixelCounter;

endmodule
